// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous data FIFO: read-mode encodings and a
// parameter sanity helper used at elaboration.
package fifo_pkg;

   localparam int unsigned FIFO_MODE_NORMAL    = 0;
   localparam int unsigned FIFO_MODE_SHOWAHEAD = 1;

   function automatic bit fifo_levels_ok(input int unsigned addr_w,
                                         input int unsigned ae_level,
                                         input int unsigned af_level);
      return (ae_level < af_level) && (af_level <= (32'd1 << addr_w));
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port, written
// so synthesis maps it onto block RAM (no reset on the array or read register).
module sdp_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sc_data_fifo.sv
// Single-clock data FIFO with registered status flags, overflow/underflow
// pulses and either normal or show-ahead read behaviour.
module sc_data_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned SHOWAHEAD = FIFO_MODE_NORMAL,
   parameter int unsigned AF_LEVEL  = 2**ADDR_W - 4,
   parameter int unsigned AE_LEVEL  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrreq,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rdreq,
   output logic [DATA_W-1:0] data_out,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   usedw,
   output logic              overflow,
   output logic              underflow
);

   if (!fifo_levels_ok(ADDR_W, AE_LEVEL, AF_LEVEL)) begin : g_bad_levels
      $error("sc_data_fifo: levels must satisfy AE_LEVEL < AF_LEVEL <= 2**ADDR_W");
   end

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] AF_L  = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_L  = (ADDR_W+1)'(AE_LEVEL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   usedw_q, usedw_d;
   logic              empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
   logic              sel_byp_q, sel_byp_d;
   logic [DATA_W-1:0] byp_q, byp_d;
   logic              wr_acc, rd_acc;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;

   // Acceptance looks only at registered flags, so a write while full is
   // dropped even if a read frees a slot on the same edge.
   assign wr_acc = wrreq && !full_q;
   assign rd_acc = rdreq && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
      rd_ptr_d = rd_ptr_q + ADDR_W'(rd_acc);
      usedw_d  = usedw_q;
      if (wr_acc && !rd_acc) begin
         usedw_d = usedw_q + (ADDR_W+1)'(1);
      end else if (rd_acc && !wr_acc) begin
         usedw_d = usedw_q - (ADDR_W+1)'(1);
      end
   end

   if (SHOWAHEAD == FIFO_MODE_SHOWAHEAD) begin : g_showahead
      // RAM continuously fetches the post-edge head; a word written into the
      // head slot on this edge is not yet readable, so it goes via the bypass.
      assign ram_rd_en   = 1'b1;
      assign ram_rd_addr = rd_ptr_d;

      always_comb begin
         sel_byp_d = sel_byp_q;
         byp_d     = byp_q;
         if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            sel_byp_d = 1'b1;
            byp_d     = data_in;
         end else if (wr_acc || rd_acc) begin
            sel_byp_d = 1'b0;
         end
      end
   end else begin : g_normal
      assign ram_rd_en   = rd_acc;
      assign ram_rd_addr = rd_ptr_q;

      // Bypass only supplies the post-reset zero until the first read.
      always_comb begin
         sel_byp_d = rd_acc ? 1'b0 : sel_byp_q;
         byp_d     = byp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         usedw_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         ae_q      <= 1'b1;
         af_q      <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         sel_byp_q <= 1'b1;
         byp_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         usedw_q   <= usedw_d;
         empty_q   <= (usedw_d == '0);
         full_q    <= (usedw_d == DEPTH);
         ae_q      <= (usedw_d <= AE_L);
         af_q      <= (usedw_d >= AF_L);
         ovf_q     <= wrreq && full_q;
         udf_q     <= rdreq && empty_q;
         sel_byp_q <= sel_byp_d;
         byp_q     <= byp_d;
      end
   end

   sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_acc && !rst),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (data_in),
      .rd_en_i   (ram_rd_en),
      .rd_addr_i (ram_rd_addr),
      .rd_data_o (ram_rd_data)
   );

   assign data_out     = sel_byp_q ? byp_q : ram_rd_data;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign usedw        = usedw_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sc_data_fifo.sv
// Directed bench for sc_data_fifo: a default instance, a depth-8 normal-mode
// instance and a depth-8 show-ahead instance share one stimulus stream.
module tb_sc_data_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wrreq = 1'b0;
   logic       rdreq = 1'b0;
   logic [7:0] data_in = 8'h00;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  d_data_out, a_data_out, s_data_out;
   logic        d_empty, d_full, d_ae, d_af, d_ovf, d_udf;
   logic        a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
   logic        s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
   logic [10:0] d_usedw;
   logic [3:0]  a_usedw, s_usedw;

   always #5 clk = ~clk;

   sc_data_fifo u_def (
      .clk(clk), .rst(rst), .wrreq(wrreq), .data_in(data_in), .rdreq(rdreq),
      .data_out(d_data_out), .empty(d_empty), .full(d_full),
      .almost_empty(d_ae), .almost_full(d_af), .usedw(d_usedw),
      .overflow(d_ovf), .underflow(d_udf)
   );

   sc_data_fifo #(.DATA_W(8), .ADDR_W(3), .SHOWAHEAD(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_a3 (
      .clk(clk), .rst(rst), .wrreq(wrreq), .data_in(data_in), .rdreq(rdreq),
      .data_out(a_data_out), .empty(a_empty), .full(a_full),
      .almost_empty(a_ae), .almost_full(a_af), .usedw(a_usedw),
      .overflow(a_ovf), .underflow(a_udf)
   );

   sc_data_fifo #(.DATA_W(8), .ADDR_W(3), .SHOWAHEAD(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_sa (
      .clk(clk), .rst(rst), .wrreq(wrreq), .data_in(data_in), .rdreq(rdreq),
      .data_out(s_data_out), .empty(s_empty), .full(s_full),
      .almost_empty(s_ae), .almost_full(s_af), .usedw(s_usedw),
      .overflow(s_ovf), .underflow(s_udf)
   );

   task automatic tick(input logic w, input logic r, input logic [7:0] d);
      wrreq   = w;
      rdreq   = r;
      data_in = d;
      @(posedge clk);
      #1;
      wrreq = 1'b0;
      rdreq = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(1'b1, 1'b1, 8'hFF);
      rst = 1'b0;
      n_vec++; if (d_usedw !== 11'd0) begin n_err++; $display("FAIL reset_usedw got %0d want 0", d_usedw); end
      n_vec++; if ({d_empty, d_full, d_ae, d_af, d_ovf, d_udf} !== 6'b101000) begin
         n_err++; $display("FAIL reset_flags_def got %b want 101000", {d_empty, d_full, d_ae, d_af, d_ovf, d_udf}); end
      n_vec++; if ({a_empty, a_full, a_ae, a_af, a_ovf, a_udf} !== 6'b101000) begin
         n_err++; $display("FAIL reset_flags_a3 got %b want 101000", {a_empty, a_full, a_ae, a_af, a_ovf, a_udf}); end
      n_vec++; if ({s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 6'b101000) begin
         n_err++; $display("FAIL reset_flags_sa got %b want 101000", {s_empty, s_full, s_ae, s_af, s_ovf, s_udf}); end
      n_vec++; if ({d_data_out, a_data_out, s_data_out} !== 24'h0) begin
         n_err++; $display("FAIL reset_data got %h want 000000", {d_data_out, a_data_out, s_data_out}); end
      n_vec++; if ({a_usedw, s_usedw} !== 8'h00) begin
         n_err++; $display("FAIL reset_usedw_small got %h want 00", {a_usedw, s_usedw}); end
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         tick(1'b1, 1'b0, 8'(i));
         n_vec++; if (d_usedw !== 11'(i)) begin n_err++; $display("FAIL basic_wr_usedw got %0d want %0d", d_usedw, i); end
         n_vec++; if (d_ae !== (i <= 4)) begin n_err++; $display("FAIL basic_wr_ae got %b want %b", d_ae, (i <= 4)); end
         n_vec++; if (d_empty !== 1'b0) begin n_err++; $display("FAIL basic_wr_empty got %b want 0", d_empty); end
      end
      for (int i = 1; i <= 5; i++) begin
         tick(1'b0, 1'b1, 8'h00);
         n_vec++; if (d_data_out !== 8'(i)) begin n_err++; $display("FAIL basic_rd_data got %h want %h", d_data_out, 8'(i)); end
         n_vec++; if (d_usedw !== 11'(5 - i)) begin n_err++; $display("FAIL basic_rd_usedw got %0d want %0d", d_usedw, 5 - i); end
      end
      n_vec++; if (d_empty !== 1'b1) begin n_err++; $display("FAIL basic_end_empty got %b want 1", d_empty); end
      n_vec++; if (d_udf !== 1'b0) begin n_err++; $display("FAIL basic_no_udf got %b want 0", d_udf); end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 1'b0, 8'h10 + 8'(k - 1));
         n_vec++; if (a_usedw !== 4'(k)) begin n_err++; $display("FAIL fill_usedw got %0d want %0d", a_usedw, k); end
         n_vec++; if (a_full !== (k == 8)) begin n_err++; $display("FAIL fill_full got %b want %b", a_full, (k == 8)); end
         n_vec++; if (a_af !== (k >= 6)) begin n_err++; $display("FAIL fill_af got %b want %b", a_af, (k >= 6)); end
         n_vec++; if (a_ae !== (k <= 2)) begin n_err++; $display("FAIL fill_ae got %b want %b", a_ae, (k <= 2)); end
      end
      tick(1'b1, 1'b0, 8'hEE);
      n_vec++; if (a_usedw !== 4'd8) begin n_err++; $display("FAIL ovf_usedw got %0d want 8", a_usedw); end
      n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %b want 1", a_ovf); end
      tick(1'b0, 1'b0, 8'h00);
      n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle got %b want 0", a_ovf); end
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 1'b1, 8'h00);
         n_vec++; if (a_data_out !== 8'h10 + 8'(k)) begin
            n_err++; $display("FAIL ovf_drain_data got %h want %h", a_data_out, 8'h10 + 8'(k)); end
      end
      n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain_empty got %b want 1", a_empty); end
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 8'h20 + 8'(k));
      tick(1'b1, 1'b1, 8'hEE);
      n_vec++; if (a_usedw !== 4'd7) begin n_err++; $display("FAIL simul_usedw got %0d want 7", a_usedw); end
      n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL simul_ovf got %b want 1", a_ovf); end
      n_vec++; if (a_full !== 1'b0) begin n_err++; $display("FAIL simul_full got %b want 0", a_full); end
      n_vec++; if (a_data_out !== 8'h20) begin n_err++; $display("FAIL simul_data got %h want 20", a_data_out); end
      for (int k = 1; k < 8; k++) begin
         tick(1'b0, 1'b1, 8'h00);
         n_vec++; if (a_data_out !== 8'h20 + 8'(k)) begin
            n_err++; $display("FAIL simul_drain_data got %h want %h", a_data_out, 8'h20 + 8'(k)); end
      end
      n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL simul_drain_empty got %b want 1", a_empty); end
   endtask

   task automatic test_showahead();
      logic [7:0] exp_q [6];
      logic       wr_v  [6];
      logic       rd_v  [6];
      logic [7:0] wd_v  [6];
      do_reset();
      tick(1'b1, 1'b0, 8'hA5);
      n_vec++; if (s_empty !== 1'b0) begin n_err++; $display("FAIL sa_first_empty got %b want 0", s_empty); end
      n_vec++; if (s_data_out !== 8'hA5) begin n_err++; $display("FAIL sa_first_data got %h want a5", s_data_out); end
      tick(1'b0, 1'b0, 8'h00);
      n_vec++; if (s_data_out !== 8'hA5) begin n_err++; $display("FAIL sa_hold_data got %h want a5", s_data_out); end
      tick(1'b0, 1'b1, 8'h00);
      n_vec++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL sa_pop_empty got %b want 1", s_empty); end
      // w r data | head expected after the edge
      wr_v = '{1, 1, 1, 0, 1, 0}; rd_v = '{0, 0, 0, 1, 1, 1};
      wd_v = '{8'hB1, 8'hB2, 8'hB3, 8'h00, 8'hB4, 8'h00};
      exp_q = '{8'hB1, 8'hB1, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      for (int i = 0; i < 6; i++) begin
         tick(wr_v[i], rd_v[i], wd_v[i]);
         n_vec++; if (s_data_out !== exp_q[i]) begin
            n_err++; $display("FAIL sa_seq_data step %0d got %h want %h", i, s_data_out, exp_q[i]); end
      end
      tick(1'b1, 1'b1, 8'hB5);
      n_vec++; if (s_data_out !== 8'hB5) begin n_err++; $display("FAIL sa_bypass_data got %h want b5", s_data_out); end
      n_vec++; if (s_usedw !== 4'd1) begin n_err++; $display("FAIL sa_bypass_usedw got %0d want 1", s_usedw); end
      tick(1'b0, 1'b1, 8'h00);
      n_vec++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL sa_final_empty got %b want 1", s_empty); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 8'h40 + 8'(k));
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b1, 8'h43 + 8'(i));
         n_vec++; if (a_data_out !== 8'h40 + 8'(i)) begin
            n_err++; $display("FAIL wrap_data cycle %0d got %h want %h", i, a_data_out, 8'h40 + 8'(i)); end
         n_vec++; if (a_usedw !== 4'd3) begin n_err++; $display("FAIL wrap_usedw cycle %0d got %0d want 3", i, a_usedw); end
      end
      tick(1'b1, 1'b0, 8'h99);
      rst = 1'b1;
      tick(1'b1, 1'b1, 8'h55);
      rst = 1'b0;
      n_vec++; if (a_usedw !== 4'd0) begin n_err++; $display("FAIL midrst_usedw got %0d want 0", a_usedw); end
      n_vec++; if ({a_empty, a_full, a_ae} !== 3'b101) begin
         n_err++; $display("FAIL midrst_flags got %b want 101", {a_empty, a_full, a_ae}); end
      n_vec++; if (a_data_out !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", a_data_out); end
      tick(1'b1, 1'b0, 8'h77);
      tick(1'b0, 1'b1, 8'h00);
      n_vec++; if (a_data_out !== 8'h77) begin n_err++; $display("FAIL postrst_data got %h want 77", a_data_out); end
      n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL postrst_empty got %b want 1", a_empty); end
   endtask

   task automatic test_underflow();
      do_reset();
      tick(1'b1, 1'b0, 8'h3C);
      tick(1'b0, 1'b1, 8'h00);
      tick(1'b0, 1'b1, 8'h00);
      n_vec++; if (d_udf !== 1'b1) begin n_err++; $display("FAIL udf_pulse got %b want 1", d_udf); end
      n_vec++; if (d_usedw !== 11'd0) begin n_err++; $display("FAIL udf_usedw got %0d want 0", d_usedw); end
      n_vec++; if (d_data_out !== 8'h3C) begin n_err++; $display("FAIL udf_data got %h want 3c", d_data_out); end
      tick(1'b0, 1'b0, 8'h00);
      n_vec++; if (d_udf !== 1'b0) begin n_err++; $display("FAIL udf_one_cycle got %b want 0", d_udf); end
      tick(1'b1, 1'b1, 8'h5A);
      n_vec++; if (d_udf !== 1'b1) begin n_err++; $display("FAIL udf_simul_pulse got %b want 1", d_udf); end
      n_vec++; if (d_usedw !== 11'd1) begin n_err++; $display("FAIL udf_simul_usedw got %0d want 1", d_usedw); end
      n_vec++; if (d_data_out !== 8'h3C) begin n_err++; $display("FAIL udf_simul_data got %h want 3c", d_data_out); end
      tick(1'b0, 1'b1, 8'h00);
      n_vec++; if (d_data_out !== 8'h5A) begin n_err++; $display("FAIL udf_after_data got %h want 5a", d_data_out); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_full_overflow();
      test_full_simul();
      test_showahead();
      test_wrap_and_reset();
      test_underflow();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
